// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_pkg
// Brief    : Lane FSM states and default comma/idle codes for the PHY blocks.
// Revision : 1.0
// ============================================================================
package phy_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } phy_state_e;

    localparam logic [7:0] c_comma_def = 8'hBC;
    localparam logic [7:0] c_idle_def  = 8'h7C;

endpackage
`default_nettype wire

// File: rtl/phy_shift_in.sv
`default_nettype none
// ============================================================================
// Module   : phy_shift_in
// Brief    : Serial shift register, candidate word and comma/idle compare.
// Revision : 1.0
// ============================================================================
module phy_shift_in
    import phy_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(c_comma_def),
    parameter logic [WIDTH-1:0] IDLE  = WIDTH'(c_idle_def)
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_word,
    output logic             o_comma,
    output logic             o_idle
);

    // The oldest bit leaves the window before it is ever compared, so only
    // WIDTH-1 history bits are stored.
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-2:0] sr_d;
    logic [WIDTH-1:0] w_word;

    always_comb begin
        w_word = {sr_q, i_data};
        sr_d   = w_word[WIDTH-2:0];
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_word  = w_word;
    assign o_comma = (w_word == COMMA);
    assign o_idle  = (w_word == IDLE);

endmodule
`default_nettype wire

// File: rtl/phy_deser_align.sv
`default_nettype none
// ============================================================================
// Module   : phy_deser_align
// Brief    : Lane receiver: comma hunt, lock/loss FSM and word output stage.
// Revision : 1.0
// ============================================================================
module phy_deser_align
    import phy_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(c_comma_def),
    parameter logic [WIDTH-1:0] IDLE       = WIDTH'(c_idle_def),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_stb,
    output logic             active,
    output logic [1:0]       state
);

    localparam int c_bit_w  = $clog2(WIDTH);
    localparam int c_lock_w = $clog2(LOCK_COUNT + 1);
    localparam int c_loss_w = $clog2(LOSS_COUNT + 1);

    localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(WIDTH - 1);
    localparam logic [c_lock_w-1:0] c_lock_max = c_lock_w'(LOCK_COUNT);
    localparam logic [c_lock_w-1:0] c_lock_one = c_lock_w'(1);
    localparam logic [c_loss_w-1:0] c_loss_max = c_loss_w'(LOSS_COUNT);

    logic [WIDTH-1:0] w_word;
    logic             w_comma;
    logic             w_idle;
    logic             w_boundary;
    logic [c_lock_w-1:0] w_comma_inc;
    logic [c_loss_w-1:0] w_slip_inc;

    phy_state_e          state_q,     state_d;
    logic [c_bit_w-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [c_lock_w-1:0] comma_cnt_q, comma_cnt_d;
    logic [c_loss_w-1:0] slip_cnt_q,  slip_cnt_d;
    logic [WIDTH-1:0]    data_out_q,  data_out_d;
    logic                valid_q,     valid_d;
    logic                stb_q,       stb_d;

    phy_shift_in #(
        .WIDTH (WIDTH),
        .COMMA (COMMA),
        .IDLE  (IDLE)
    ) u_shift_in (
        .clk_8f  (clk_8f),
        .reset   (reset),
        .i_data  (data_in),
        .o_word  (w_word),
        .o_comma (w_comma),
        .o_idle  (w_idle)
    );

    assign w_boundary  = (bit_cnt_q == c_bit_last);
    assign w_comma_inc = comma_cnt_q + 1'b1;
    assign w_slip_inc  = slip_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = w_boundary ? '0 : bit_cnt_q + 1'b1;
        comma_cnt_d = comma_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;

        case (state_q)
            ST_HUNT: begin
                // Any comma, at any offset, re-anchors the word boundary.
                if (w_comma) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = c_lock_one;
                    state_d     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_comma) begin
                        comma_cnt_d = w_comma_inc;
                        if (w_comma_inc == c_lock_max) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = ST_HUNT;
                    end
                end
            end

            ST_LOCKED: begin
                if (w_boundary) begin
                    data_out_d = w_word;
                    stb_d      = 1'b1;
                    valid_d    = !w_comma && !w_idle;
                    if (w_comma) begin
                        slip_cnt_d = '0;
                    end
                end else if (w_comma) begin
                    // A comma off the boundary means the lane has slipped.
                    if (w_slip_inc == c_loss_max) begin
                        state_d     = ST_HUNT;
                        bit_cnt_d   = '0;
                        comma_cnt_d = '0;
                        slip_cnt_d  = '0;
                        data_out_d  = '0;
                        valid_d     = 1'b0;
                    end else begin
                        slip_cnt_d = w_slip_inc;
                    end
                end
            end

            default: begin
                state_d     = ST_HUNT;
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
                slip_cnt_d  = '0;
                data_out_d  = '0;
                valid_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            slip_cnt_q  <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            stb_q       <= stb_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign word_stb  = stb_q;
    assign active    = (state_q == ST_LOCKED);
    assign state     = state_q;

endmodule
`default_nettype wire

// File: doc/phy_deser_align.md
# phy_deser_align

Parametrised serial-to-parallel receiver for one PHY lane. It shifts in one bit per clk_8f cycle and hunts for the comma character at any bit offset. After LOCK_COUNT consecutive aligned commas it declares the lane active and emits one word per WIDTH cycles, with a valid flag that excludes comma and idle characters. It sits after the lane serializer/serial link and feeds the byte un-striping logic. It supersedes the fixed 8-bit receive path with configurable width, comma/idle codes, lock depth and loss-of-alignment detection.

## Interface
- WIDTH, 8, word width in bits (>= 2)
- COMMA, 8'hBC, alignment character (WIDTH bits)
- IDLE, 8'h7C, idle filler character (WIDTH bits)
- LOCK_COUNT, 4, consecutive aligned commas required for lock (>= 1)
- LOSS_COUNT, 4, misaligned comma matches that drop lock (>= 1)
- clk_8f  in  1  bit clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- data_in  in  1  serial bit, MSB of each word first
- data_out  out  WIDTH  last aligned word received while locked
- valid_out  out  1  data_out is payload (not COMMA, not IDLE)
- word_stb  out  1  one-cycle pulse: data_out updated this cycle
- active  out  1  lane locked
- state  out  2  current FSM state (debug)

## Operation
- Shift register sr[WIDTH-1:0] shifts left every cycle: sr <= {sr[WIDTH-2:0], data_in}. Candidate word w = {sr[WIDTH-2:0], data_in}.
- Bit counter bit_cnt counts 0..WIDTH-1 with wrap. The boundary is the cycle where bit_cnt == WIDTH-1, outside HUNT.
- HUNT (2'd0): each cycle, if w == COMMA: bit_cnt <= 0 and comma_cnt <= 1. Go to LOCKED if LOCK_COUNT == 1, else ALIGN.
- ALIGN (2'd1): at each boundary, if w == COMMA, increment comma_cnt. Go to LOCKED when it reaches LOCK_COUNT. If w != COMMA: comma_cnt <= 0, go to HUNT.
- LOCKED (2'd2): active = 1. At each boundary: data_out <= w, word_stb <= 1, valid_out <= (w != COMMA && w != IDLE).
- Loss of alignment in LOCKED: on a non-boundary cycle with w == COMMA, increment slip_cnt. An aligned COMMA at a boundary clears slip_cnt. When slip_cnt reaches LOSS_COUNT: go to HUNT, active <= 0, valid_out <= 0, and clear all counters. The same edge may re-enter ALIGN if w == COMMA is evaluated in HUNT on the next cycle.
- State 2'd3 is unused; if entered, go to HUNT.
- The lock edge itself produces no word. The first word_stb comes at the next boundary, WIDTH cycles later.
- In HUNT/ALIGN: data_out holds 0, valid_out = 0, word_stb = 0.

## Timing
- Reset values: data_out = 0, valid_out = 0, word_stb = 0, active = 0, state = HUNT, sr = 0, all counters 0. Reset takes effect immediately, without waiting for a clock edge. Outputs follow registered rules from the first edge after deassertion.
- Latency: the word whose last bit is sampled at edge E appears on data_out/valid_out/word_stb right after E, i.e. registered on E.
- Lock timing: first comma completes at E0. active rises at E0 + (LOCK_COUNT-1)*WIDTH. First word_stb is at E0 + LOCK_COUNT*WIDTH.
- word_stb is spaced exactly WIDTH cycles while locked and is high for 1 cycle only.
- valid_out and data_out change only with word_stb or on lock loss/reset.
- Simultaneous events: at a boundary, the boundary rule wins, and a matching COMMA counts as aligned, not as a slip.
- Counters: comma_cnt and slip_cnt are $clog2(max+1) wide and saturate at their threshold, never wrapping.

## Structure
- Shared package phy_pkg: state enum (HUNT, ALIGN, LOCKED), default COMMA/IDLE constants, shared with the serializer and striping blocks.
- One sub-module, phy_shift_in: shift register plus candidate word and comma compare. The FSM, counters and output registers stay in phy_deser_align.

## Test plan
- Reset: hold reset for 3 cycles mid-stream, then release -> all outputs 0, state = HUNT, no word_stb until a comma is found.
- Lock, WIDTH=8: 3 random bits, then 4× 0xBC -> active rises on the last bit of the 4th 0xBC, with no word_stb before it.
- Data, WIDTH=8: after lock send 0x90, 0xBC, 0x7C, 0x0A -> word_stb every 8 cycles, data_out = 90/BC/7C/0A, valid_out = 1/0/0/1.
- Aborted align: 0xBC, 0xBC, 0x55 -> back to HUNT at the 0x55 boundary, active never rises.
- Slip: when locked, insert one extra bit, then send 0xBC continuously -> after 4 misaligned matches active falls; 4 aligned commas later (new offset) active rises again.
- Variant WIDTH=10, COMMA=10'h17C, LOCK_COUNT=1: a single comma locks -> active is set on that edge, first word_stb comes 10 cycles later; async reset asserted mid-word clears active at once.
